// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory bus between the fetch unit and the instruction memory.
//
// Signals
//   req_valid   fetch -> mem   request valid
//   req_ready   mem -> fetch   memory accepts the request this cycle
//   req_addr    fetch -> mem   64-bit word-aligned request address
//   resp_valid  mem -> fetch   32-bit instruction returned (in request order)
//   resp_data   mem -> fetch   returned instruction word
//
// Modports
//   master  used by the fetch unit
//   slave   used by the instruction memory
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues sequential word fetches to the
// instruction memory, pairs in-order responses with the PC recorded at request
// time, and buffers {pc, inst} pairs for the decoder. A flush redirects the
// fetch PC and discards every response still in flight.
//
// Parameters
//   RESET_PC         first fetch address after reset
//   MAX_OUTSTANDING  limit on in-flight requests plus buffered instructions
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall_fetch_i  decoder not accepting this cycle
//   flush_fetch_i  flush plus redirect this cycle
//   redirect_pc_i  new fetch PC, sampled when flush_fetch_i=1
//   imem           instruction-memory bus (fetch_unit_if.master)
//   f1_valid_o     f1_pc_o / f1_inst_o hold a valid instruction
//   f1_pc_o        PC of the head instruction
//   f1_inst_o      head instruction word
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_8000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_fetch_i,
  input  logic               flush_fetch_i,
  input  logic [63:0]        redirect_pc_i,
  fetch_unit_if.master       imem,
  output logic               f1_valid_o,
  output logic [63:0]        f1_pc_o,
  output logic [31:0]        f1_inst_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW:0]   LIMIT    = (CW+1)'(MAX_OUTSTANDING);

  // Fetch PC and bookkeeping counters
  logic [63:0]   r_pc;
  logic [CW-1:0] r_outstanding;   // all requests in flight, stale included
  logic [CW-1:0] r_discard;       // in-flight responses still to be dropped
  logic [CW-1:0] r_buf_count;

  // In-flight PC queue (only live, non-stale requests)
  logic [63:0]   r_pcq [MAX_OUTSTANDING];
  logic [PW-1:0] r_pcq_wr;
  logic [PW-1:0] r_pcq_rd;

  // Output FIFO of {pc, inst}
  logic [63:0]   r_fifo_pc   [MAX_OUTSTANDING];
  logic [31:0]   r_fifo_inst [MAX_OUTSTANDING];
  logic [PW-1:0] r_fifo_wr;
  logic [PW-1:0] r_fifo_rd;

  logic [CW:0]   w_in_use;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_in_use = {1'b0, r_outstanding} + {1'b0, r_buf_count};

  // Gating with rst_n keeps the request low throughout reset while still
  // letting the first request go out in the very first cycle after release.
  // Nothing here depends on req_ready.
  assign w_req_valid = rst_n & ~flush_fetch_i & (w_in_use < LIMIT);
  assign w_accept    = w_req_valid & imem.req_ready;

  // A response is buffered only if it belongs to the current stream and no
  // flush is throwing it away this cycle.
  assign w_push = imem.resp_valid & ~flush_fetch_i & (r_discard == '0);
  assign w_pop  = (r_buf_count != '0) & ~stall_fetch_i & ~flush_fetch_i;

  assign imem.req_valid = w_req_valid;
  assign imem.req_addr  = r_pc;

  assign f1_valid_o = (r_buf_count != '0);
  assign f1_pc_o    = r_fifo_pc[r_fifo_rd];
  assign f1_inst_o  = r_fifo_inst[r_fifo_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= {RESET_PC[63:2], 2'b00};
      r_outstanding <= '0;
      r_discard     <= '0;
      r_buf_count   <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_pcq[i]       <= '0;
        r_fifo_pc[i]   <= '0;
        r_fifo_inst[i] <= '0;
      end
    end else begin
      // Stale and live requests alike leave the in-flight count on response.
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem.resp_valid);

      if (flush_fetch_i) begin
        r_pc        <= redirect_pc_i & ~64'h3;
        // Everything still in flight after this cycle's response is stale.
        r_discard   <= r_outstanding - CW'(imem.resp_valid);
        r_buf_count <= '0;
        r_pcq_wr    <= '0;
        r_pcq_rd    <= '0;
        r_fifo_wr   <= '0;
        r_fifo_rd   <= '0;
      end else begin
        if (w_accept) begin
          r_pc            <= r_pc + 64'd4;
          r_pcq[r_pcq_wr] <= r_pc;
          r_pcq_wr        <= f_ptr_inc(r_pcq_wr);
        end

        if (imem.resp_valid && (r_discard != '0)) begin
          r_discard <= r_discard - 1'b1;
        end

        if (w_push) begin
          r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
          r_fifo_inst[r_fifo_wr] <= imem.resp_data;
          r_fifo_wr              <= f_ptr_inc(r_fifo_wr);
          r_pcq_rd               <= f_ptr_inc(r_pcq_rd);
        end

        if (w_pop) begin
          r_fifo_rd <= f_ptr_inc(r_fifo_rd);
        end

        r_buf_count <= r_buf_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural memory (queue of requests
// tagged with a stream epoch and a due cycle) and an expected-delivery queue
// predict the request port and the f1 head every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          MAXO     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall;
  logic        flush;
  logic [63:0] redir;
  logic        f1_valid;
  logic [63:0] f1_pc;
  logic [31:0] f1_inst;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_fetch_i(stall),
    .flush_fetch_i(flush),
    .redirect_pc_i(redir),
    .imem(imem),
    .f1_valid_o(f1_valid),
    .f1_pc_o(f1_pc),
    .f1_inst_o(f1_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } mem_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } fe_t;

  mem_t        mem_q[$];   // requests accepted by memory, oldest first
  fe_t         exp_q[$];   // instructions expected at f1, head first
  logic [63:0] m_pc;
  int          epoch;
  int          cyc;
  int          n_assert;
  int          n_fail;
  int          p_ready;
  int          p_resp;
  int          lat_max;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    imem.resp_valid = 1'b0;
    imem.req_ready  = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check("rst_req_valid", {63'd0, imem.req_valid}, 64'd0);
    check("rst_f1_valid", {63'd0, f1_valid}, 64'd0);
    check("rst_f1_pc", f1_pc, 64'd0);
    check("rst_f1_inst", {32'd0, f1_inst}, 64'd0);
    mem_q.delete();
    exp_q.delete();
    m_pc = RESET_PC;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input bit do_flush, input logic [63:0] r, input bit do_stall);
    bit   exp_rv;
    bit   acc;
    bit   rv;
    mem_t e;
    fe_t  f;
    @(negedge clk);
    flush = do_flush;
    redir = r;
    stall = do_stall;
    imem.req_ready = ($urandom_range(99) < p_ready);
    rv = 1'b0;
    if (mem_q.size() != 0) begin
      if (mem_q[0].due <= cyc && $urandom_range(99) < p_resp) rv = 1'b1;
    end
    imem.resp_valid = rv;
    if (rv) imem.resp_data = inst_of(mem_q[0].addr);
    else    imem.resp_data = $urandom();
    #1;
    exp_rv = !do_flush && (mem_q.size() + exp_q.size() < MAXO);
    check("req_valid", {63'd0, imem.req_valid}, {63'd0, exp_rv});
    if (exp_rv) check("req_addr", imem.req_addr, m_pc);
    check("f1_valid", {63'd0, f1_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("f1_pc", f1_pc, exp_q[0].pc);
      check("f1_inst", {32'd0, f1_inst}, {32'd0, exp_q[0].inst});
    end
    acc = exp_rv && imem.req_ready;
    if (exp_q.size() != 0 && !do_stall && !do_flush) void'(exp_q.pop_front());
    if (rv) begin
      e = mem_q.pop_front();
      if (!do_flush && e.epoch == epoch) begin
        f.pc   = e.addr;
        f.inst = inst_of(e.addr);
        exp_q.push_back(f);
      end
    end
    if (acc) begin
      e.addr  = m_pc;
      e.epoch = epoch;
      e.due   = cyc + 1 + int'($urandom_range(lat_max));
      mem_q.push_back(e);
      m_pc += 64'd4;
    end
    if (do_flush) begin
      exp_q.delete();
      m_pc = {r[63:2], 2'b00};
      epoch++;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic [63:0] rr;
    n_assert = 0;
    n_fail   = 0;
    epoch    = 0;
    cyc      = 0;
    p_ready  = 100;
    p_resp   = 100;
    lat_max  = 0;
    stall    = 1'b0;
    flush    = 1'b0;
    redir    = '0;
    imem.req_ready  = 1'b1;
    imem.resp_valid = 1'b0;
    imem.resp_data  = '0;
    m_pc = RESET_PC;

    // Reset, then continuous 1-per-cycle flow with a 1-cycle memory
    do_reset(3);
    repeat (12) step(1'b0, '0, 1'b0);

    // Stall long enough to fill the buffer, then release
    repeat (8) step(1'b0, '0, 1'b1);
    repeat (10) step(1'b0, '0, 1'b0);

    // Memory not ready for 10 cycles: request and address held
    p_ready = 0;
    repeat (10) step(1'b0, '0, 1'b0);
    p_ready = 100;
    repeat (6) step(1'b0, '0, 1'b0);

    // Flush with requests in flight, misaligned redirect
    p_resp = 0;
    repeat (4) step(1'b0, '0, 1'b0);
    step(1'b1, 64'h0000_0000_8000_0102, 1'b0);
    p_resp = 100;
    repeat (8) step(1'b0, '0, 1'b0);

    // Flush on a cycle with a response arriving
    step(1'b1, 64'h0000_0000_8000_0200, 1'b0);
    repeat (6) step(1'b0, '0, 1'b0);

    // Back-to-back flushes with stale responses pending
    p_resp = 0;
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, 64'h100, 1'b0);
    step(1'b1, 64'h200, 1'b0);
    p_resp = 100;
    repeat (10) step(1'b0, '0, 1'b0);

    // 64-bit PC wrap
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        p_ready = int'($urandom_range(30, 100));
        p_resp  = int'($urandom_range(30, 100));
        lat_max = int'($urandom_range(0, 3));
      end
      if (i == 1500) do_reset(2);
      rr = {$urandom(), $urandom()};
      step($urandom_range(99) < 4, rr, $urandom_range(99) < 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
